// File: rtl/conv_window_3x3.sv
// Streaming 3x3 window generator for a raster-order pixel stream.
// Two line buffers hold the previous two rows; a 3x3 register array holds the
// current neighbourhood, presented row-major on Data_Out0..Data_Out8.
// Windows are flagged only where the full neighbourhood lies inside the image
// ("valid" convolution, no padding). Pixel bits pass through untouched.
module conv_window_3x3 #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Valid_In,
    output logic [DATA_WIDTH-1:0] Data_Out0,
    output logic [DATA_WIDTH-1:0] Data_Out1,
    output logic [DATA_WIDTH-1:0] Data_Out2,
    output logic [DATA_WIDTH-1:0] Data_Out3,
    output logic [DATA_WIDTH-1:0] Data_Out4,
    output logic [DATA_WIDTH-1:0] Data_Out5,
    output logic [DATA_WIDTH-1:0] Data_Out6,
    output logic [DATA_WIDTH-1:0] Data_Out7,
    output logic [DATA_WIDTH-1:0] Data_Out8,
    output logic                  Valid_Out,
    output logic                  Frame_Done
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(2);

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];  // previous row
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];  // row before that
    logic [DATA_WIDTH-1:0] win [9];          // row-major 3x3 window

    logic [DATA_WIDTH-1:0] lb0_tap;
    logic [DATA_WIDTH-1:0] lb1_tap;

    // Oldest entry of each line buffer is the pixel one / two rows above.
    assign lb0_tap = lb0[IMG_WIDTH-1];
    assign lb1_tap = lb1[IMG_WIDTH-1];

    // Line buffers: shift one place per accepted pixel; LB1 is fed from LB0.
    // NOTE: storage arrays carry no reset; their contents are never observed
    // before two full rows have been written, and omitting it keeps them RAM/SRL-friendly.
    always_ff @(posedge clk) begin
        if (Valid_In && !rst) begin
            lb0[0] <= Data_In;
            lb1[0] <= lb0_tap;
            for (int i = 1; i < IMG_WIDTH; i++) begin
                lb0[i] <= lb0[i-1];
                lb1[i] <= lb1[i-1];
            end
        end
    end

    // Window shift, position counters and registered strobes.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
            col        <= '0;
            row        <= '0;
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
            if (Valid_In) begin
                // Shift columns left; new right column comes from the taps.
                win[0] <= win[1];
                win[1] <= win[2];
                win[3] <= win[4];
                win[4] <= win[5];
                win[6] <= win[7];
                win[7] <= win[8];
                win[2] <= lb1_tap;
                win[5] <= lb0_tap;
                win[8] <= Data_In;

                // First two pixels of a row and first two rows never complete a window.
                Valid_Out  <= (row >= ROW_FIRST) && (col >= COL_FIRST);
                Frame_Done <= (row == ROW_LAST)  && (col == COL_LAST);

                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign Data_Out0 = win[0];
    assign Data_Out1 = win[1];
    assign Data_Out2 = win[2];
    assign Data_Out3 = win[3];
    assign Data_Out4 = win[4];
    assign Data_Out5 = win[5];
    assign Data_Out6 = win[6];
    assign Data_Out7 = win[7];
    assign Data_Out8 = win[8];

endmodule

// File: tb/tb_conv_window_3x3.sv
// Directed bench for conv_window_3x3: a 4x4 instance for hand-checked windows,
// stalls, back-to-back frames and resets, plus a default 28x28 instance fed
// random FP32 words and compared against a frame-array reference.
module tb_conv_window_3x3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // ---------------- 4x4 instance ----------------
    logic [31:0] s_din;
    logic        s_vin;
    logic [31:0] s_dout [9];
    logic        s_vout, s_fd;

    conv_window_3x3 #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_small (
        .clk(clk), .rst(rst), .Data_In(s_din), .Valid_In(s_vin),
        .Data_Out0(s_dout[0]), .Data_Out1(s_dout[1]), .Data_Out2(s_dout[2]),
        .Data_Out3(s_dout[3]), .Data_Out4(s_dout[4]), .Data_Out5(s_dout[5]),
        .Data_Out6(s_dout[6]), .Data_Out7(s_dout[7]), .Data_Out8(s_dout[8]),
        .Valid_Out(s_vout), .Frame_Done(s_fd)
    );

    // ---------------- 28x28 default instance ----------------
    logic [31:0] b_din;
    logic        b_vin;
    logic [31:0] b_dout [9];
    logic        b_vout, b_fd;

    conv_window_3x3 u_big (
        .clk(clk), .rst(rst), .Data_In(b_din), .Valid_In(b_vin),
        .Data_Out0(b_dout[0]), .Data_Out1(b_dout[1]), .Data_Out2(b_dout[2]),
        .Data_Out3(b_dout[3]), .Data_Out4(b_dout[4]), .Data_Out5(b_dout[5]),
        .Data_Out6(b_dout[6]), .Data_Out7(b_dout[7]), .Data_Out8(b_dout[8]),
        .Valid_Out(b_vout), .Frame_Done(b_fd)
    );

    int n_cmp = 0;
    int n_err = 0;
    int s_pulses = 0;
    int s_fds = 0;
    logic [31:0] pix [28][28];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock on the small instance; sample #1 after the edge and tally strobes.
    task automatic step_s();
        @(posedge clk);
        #1;
        if (s_vout === 1'b1) s_pulses++;
        if (s_fd === 1'b1) s_fds++;
    endtask

    task automatic push_s(input logic [31:0] v);
        s_din = v;
        s_vin = 1'b1;
        step_s();
        s_vin = 1'b0;
    endtask

    // Expected window completed by pixel (r,c) of a 4x4 frame whose pixel k = base + k.
    task automatic check_win_s(input string tag, input int base, input int r, input int c);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s d%0d", tag, i), s_dout[i],
                32'(base + (r - 2 + i / 3) * 4 + (c - 2 + i % 3)));
        end
    endtask

    task automatic check_zero_s(input string tag);
        chk({tag, " vout"}, {31'd0, s_vout}, 32'd0);
        chk({tag, " fd"},   {31'd0, s_fd},   32'd0);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s d%0d", tag, i), s_dout[i], 32'd0);
        end
    endtask

    // Full 4x4 frame of pixels base..base+15, optionally with an idle cycle after each.
    task automatic frame_s(input string tag, input int base, input bit toggle);
        int p0, f0, r, c;
        bit ev;
        p0 = s_pulses;
        f0 = s_fds;
        for (int k = 0; k < 16; k++) begin
            r  = k / 4;
            c  = k % 4;
            ev = (r >= 2) && (c >= 2);
            push_s(32'(base + k));
            chk($sformatf("%s k%0d vout", tag, k), {31'd0, s_vout}, {31'd0, ev});
            chk($sformatf("%s k%0d fd", tag, k), {31'd0, s_fd}, (k == 15) ? 32'd1 : 32'd0);
            if (ev) check_win_s($sformatf("%s k%0d", tag, k), base, r, c);
            if (toggle) begin
                step_s();
                chk($sformatf("%s idle%0d vout", tag, k), {31'd0, s_vout}, 32'd0);
                chk($sformatf("%s idle%0d fd", tag, k), {31'd0, s_fd}, 32'd0);
                if (ev) check_win_s($sformatf("%s hold%0d", tag, k), base, r, c);
            end
        end
        chk({tag, " pulses"}, 32'(s_pulses - p0), 32'd4);
        chk({tag, " frame_done"}, 32'(s_fds - f0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp, bf;
        bit ev;
        rst   = 1'b1;
        s_vin = 1'b0;
        s_din = '0;
        b_vin = 1'b0;
        b_din = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero_s("reset");
        rst = 1'b0;

        // Frame A (k=0..15) followed immediately by frame B (k=16..31)
        frame_s("frameA", 0, 1'b0);
        frame_s("frameB", 16, 1'b0);

        // Hand-written spot check: last window of frame B
        chk("frameB last d0", s_dout[0], 32'h15);
        chk("frameB last d8", s_dout[8], 32'h1F);

        // Same frame with Valid_In toggling
        frame_s("toggle", 0, 1'b1);

        // Reset mid-frame after k=6, then a fresh frame 100..115
        for (int k = 0; k <= 6; k++) push_s(32'(k));
        rst = 1'b1;
        step_s();
        check_zero_s("midrst");
        rst = 1'b0;
        frame_s("afterrst", 100, 1'b0);
        chk("afterrst first-win literal d4", 32'(105), 32'(100 + 5));

        // Reset coincident with a valid pixel: pixel dropped, outputs cleared
        push_s(32'h1234);
        rst   = 1'b1;
        s_din = 32'hDEAD;
        s_vin = 1'b1;
        step_s();
        rst   = 1'b0;
        s_vin = 1'b0;
        check_zero_s("rstvalid");
        frame_s("postdrop", 200, 1'b0);

        // Default 28x28 with random data against a frame-array reference
        bp = 0;
        bf = 0;
        for (int r = 0; r < 28; r++) begin
            for (int c = 0; c < 28; c++) begin
                b_din     = $urandom;
                pix[r][c] = b_din;
                b_vin     = 1'b1;
                @(posedge clk);
                #1;
                ev = (r >= 2) && (c >= 2);
                if (b_vout === 1'b1) bp++;
                if (b_fd === 1'b1) bf++;
                chk($sformatf("big r%0d c%0d vout", r, c), {31'd0, b_vout}, {31'd0, ev});
                chk($sformatf("big r%0d c%0d fd", r, c), {31'd0, b_fd},
                    (r == 27 && c == 27) ? 32'd1 : 32'd0);
                if (ev) begin
                    for (int i = 0; i < 9; i++) begin
                        chk($sformatf("big r%0d c%0d d%0d", r, c, i), b_dout[i],
                            pix[r - 2 + i / 3][c - 2 + i % 3]);
                    end
                end
            end
        end
        b_vin = 1'b0;
        chk("big pulses", 32'(bp), 32'd676);
        chk("big frame_done", 32'(bf), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
